// File: rtl/mult_div_unit_pkg.sv
// Shared CPU constants for the HI/LO multiply-divide unit.
// Holds the operation encodings, FSM states and default busy lengths.
package mult_div_unit_pkg;

    localparam int WORD_W          = 32;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// The result is computed at launch and held pending until busy drops.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       pend_q, pend_d;
    logic              pend_wr_q, pend_wr_d;
    logic              busy_q, busy_d;
    logic [WORD_W-1:0] hi_q, hi_d;
    logic [WORD_W-1:0] lo_q, lo_d;
    logic              launch;
    logic              done;

    // The unsigned case gets a zero extension bit, so one signed multiply covers both.
    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                          input logic is_signed);
        logic signed [32:0] sx;
        logic signed [32:0] sy;
        logic signed [63:0] p;
        sx = {is_signed & x[31], x};
        sy = {is_signed & y[31], y};
        p  = sx * sy;
        return p;
    endfunction

    // Divide magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 wraps back to 0x80000000.
    function automatic logic [63:0] div64(input logic [31:0] x, input logic [31:0] y,
                                          input logic is_signed);
        logic [31:0] mx, my, q, r;
        logic        neg_q, neg_r;
        neg_r = is_signed & x[31];
        neg_q = is_signed & (x[31] ^ y[31]);
        mx    = neg_r ? -x : x;
        my    = (is_signed & y[31]) ? -y : y;
        if (my == '0) begin
            my = 32'd1;
        end
        q = mx / my;
        r = mx % my;
        return {(neg_r ? -r : r), (neg_q ? -q : q)};
    endfunction

    assign launch = (state_q == ST_IDLE) && start && !op[2];
    assign done   = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch) state_d = ST_RUN;
            ST_RUN:  if (done)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A divide by zero still occupies the unit but never commits.
    always_comb begin
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (launch) begin
            pend_d    = op[1] ? div64(a, b, !op[0]) : mul64(a, b, !op[0]);
            pend_wr_d = !(op[1] && (b == '0));
            cnt_d     = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (done && pend_wr_q) begin
                hi_d = pend_q[63:32];
                lo_d = pend_q[31:0];
            end
        end else if (start && (op == OP_MTHI)) begin
            hi_d = a;
        end else if (start && (op == OP_MTLO)) begin
            lo_d = a;
        end
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
